// File: rtl/cpu7_dbus_pkg.sv
// Shared types for the cpu7 data-bus outstanding-request queue.
// Holds the per-entry control struct and pointer-width helper used by the queue and its perf counters.
package cpu7_dbus_pkg;

  localparam int WSTRB_W = 4;

  // Address and store data live in separate GRLEN-wide arrays inside the queue.
  typedef struct packed {
    logic               wr;
    logic [WSTRB_W-1:0] wstrb;
    logic               killed;
    logic               issued;
  } entry_ctrl_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cpu7_dbus_perf.sv
// Saturating performance counters for the data-bus queue.
// Present only in builds that define CPU7_DBUS_PERF_EN.
module cpu7_dbus_perf
  import cpu7_dbus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        full_evt,
  input  logic        killed_evt,
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_killed_resp
);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_full_cycles <= '0;
      perf_killed_resp <= '0;
    end else begin
      if (full_evt && !(&perf_full_cycles))
        perf_full_cycles <= perf_full_cycles + 32'd1;
      if (killed_evt && !(&perf_killed_resp))
        perf_killed_resp <= perf_killed_resp + 32'd1;
    end
  end

endmodule

// File: rtl/cpu7_dbus_queue.sv
// In-order outstanding-request queue between the EXU data bus and the memory port.
// Optional perf counters are built when CPU7_DBUS_PERF_EN is defined.
module cpu7_dbus_queue
  import cpu7_dbus_pkg::*;
#(
  parameter int GRLEN = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_req,
  input  logic               data_wr,
  input  logic [WSTRB_W-1:0] data_wstrb,
  input  logic [GRLEN-1:0]   data_addr,
  input  logic [GRLEN-1:0]   data_wdata,
  input  logic               data_cancel,
  output logic               data_addr_ok,
  output logic               data_data_ok_m,
  output logic [GRLEN-1:0]   data_rdata_m,
  output logic               data_req_empty,
  output logic               mem_req,
  output logic               mem_wr,
  output logic [WSTRB_W-1:0] mem_wstrb,
  output logic [GRLEN-1:0]   mem_addr,
  output logic [GRLEN-1:0]   mem_wdata,
  input  logic               mem_addr_ok,
  input  logic               mem_data_ok,
  input  logic [GRLEN-1:0]   mem_rdata
`ifdef CPU7_DBUS_PERF_EN
  ,
  output logic [31:0]        perf_full_cycles,
  output logic [31:0]        perf_killed_resp
`endif
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  entry_ctrl_t      ctrl    [DEPTH];
  logic [GRLEN-1:0] addr_q  [DEPTH];
  logic [GRLEN-1:0] wdata_q [DEPTH];

  logic [PTR_W-1:0] alloc_ptr, iss_ptr, ret_ptr;
  logic [CNT_W-1:0] count, pend;

  logic accept, iss_valid, iss_killed, issue, discard;
  logic resp_retire, drop_retire, retire, resp_live;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    data_addr_ok = !reset && (count < DEPTH_C);
    accept       = data_req && data_addr_ok;
    iss_valid    = (pend != '0);
    iss_killed   = ctrl[iss_ptr].killed;
    // A cancel this cycle already covers the entry at iss_ptr, so it must not go out.
    mem_req      = !reset && iss_valid && !iss_killed && !data_cancel;
    issue        = mem_req && mem_addr_ok;
    discard      = iss_valid && iss_killed;
    resp_retire  = mem_data_ok && (count != '0) && ctrl[ret_ptr].issued;
    // count > pend means the oldest entry has already been passed by iss_ptr.
    drop_retire  = !resp_retire && (count > pend) &&
                   ctrl[ret_ptr].killed && !ctrl[ret_ptr].issued;
    retire       = resp_retire || drop_retire;
    resp_live    = resp_retire && !ctrl[ret_ptr].killed && !data_cancel;
  end

  assign mem_wr         = ctrl[iss_ptr].wr;
  assign mem_wstrb      = ctrl[iss_ptr].wstrb;
  assign mem_addr       = addr_q[iss_ptr];
  assign mem_wdata      = wdata_q[iss_ptr];
  assign data_req_empty = (count == '0);

  // NOTE: state uses non-blocking assignments so every read in this block sees start-of-cycle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr      <= '0;
      iss_ptr        <= '0;
      ret_ptr        <= '0;
      count          <= '0;
      pend           <= '0;
      data_data_ok_m <= 1'b0;
      data_rdata_m   <= '0;
      for (int i = 0; i < DEPTH; i++) ctrl[i] <= '0;
    end else begin
      // Killing every slot is safe: free slots are rewritten on accept, which wins below.
      if (data_cancel)
        for (int i = 0; i < DEPTH; i++) ctrl[i].killed <= 1'b1;
      if (issue)
        ctrl[iss_ptr].issued <= 1'b1;
      if (accept) begin
        ctrl[alloc_ptr] <= '{wr: data_wr, wstrb: data_wstrb, killed: 1'b0, issued: 1'b0};
        alloc_ptr       <= alloc_ptr + PTR_W'(1);
      end
      if (issue || discard)
        iss_ptr <= iss_ptr + PTR_W'(1);
      if (retire)
        ret_ptr <= ret_ptr + PTR_W'(1);
      count          <= count + CNT_W'(accept) - CNT_W'(retire);
      pend           <= pend + CNT_W'(accept) - CNT_W'(issue || discard);
      data_data_ok_m <= resp_live;
      data_rdata_m   <= (resp_live && !ctrl[ret_ptr].wr) ? mem_rdata : '0;
    end
  end

  // NOTE: the payload arrays carry no reset; the ctrl bits decide whether any slot is meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[alloc_ptr]  <= data_addr;
      wdata_q[alloc_ptr] <= data_wdata;
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    mem_data_ok |-> ((count != '0) && ctrl[ret_ptr].issued));

`ifdef CPU7_DBUS_PERF_EN
  logic full_evt, killed_evt;
  assign full_evt   = data_req && (count == DEPTH_C);
  assign killed_evt = resp_retire && !resp_live;

  cpu7_dbus_perf u_perf (
    .clk              (clk),
    .reset            (reset),
    .full_evt         (full_evt),
    .killed_evt       (killed_evt),
    .perf_full_cycles (perf_full_cycles),
    .perf_killed_resp (perf_killed_resp)
  );
`endif

endmodule

// File: tb/tb_cpu7_dbus_queue.sv
// Bench for cpu7_dbus_queue: queue-level reference model checked every cycle plus directed scenarios.
// Build with CPU7_DBUS_PERF_EN defined to also exercise the perf counters.
`timescale 1ns/1ps
module tb_cpu7_dbus_queue;
  localparam int GRLEN = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             data_req, data_wr, data_cancel;
  logic [3:0]       data_wstrb;
  logic [GRLEN-1:0] data_addr, data_wdata;
  logic             data_addr_ok, data_data_ok_m, data_req_empty;
  logic [GRLEN-1:0] data_rdata_m;
  logic             mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]       mem_wstrb;
  logic [GRLEN-1:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CPU7_DBUS_PERF_EN
  logic [31:0]      perf_full_cycles, perf_killed_resp;
`endif

  always #5 clk = ~clk;

  cpu7_dbus_queue #(.GRLEN(GRLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_cancel(data_cancel),
    .data_addr_ok(data_addr_ok), .data_data_ok_m(data_data_ok_m),
    .data_rdata_m(data_rdata_m), .data_req_empty(data_req_empty),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
`ifdef CPU7_DBUS_PERF_EN
    , .perf_full_cycles(perf_full_cycles), .perf_killed_resp(perf_killed_resp)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of live requests with their life-cycle flags.
  typedef struct {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          killed;
    bit          issued;
    bit          gone;
  } req_t;

  req_t        mq[$];
  bit          exp_ok    = 1'b0;
  logic [31:0] exp_rdata = '0;
  bit          chk_en    = 1'b0;
  int          m_idx;
  bit          m_req, m_free, m_acc;
  req_t        m_t;

  always @(negedge clk) begin
    if (chk_en) begin
      m_idx = -1;
      for (int i = 0; i < mq.size(); i++)
        if (m_idx < 0 && !mq[i].issued && !mq[i].gone) m_idx = i;
      m_req = !reset && (m_idx >= 0) && !data_cancel;
      if (m_idx >= 0) m_req = m_req && !mq[m_idx].killed;

      check("addr_ok", data_addr_ok, !reset && (mq.size() < DEPTH));
      check("empty", data_req_empty, mq.size() == 0);
      check("mem_req", mem_req, m_req);
      if (m_req) begin
        check("mem_addr", mem_addr, mq[m_idx].addr);
        check("mem_wr", mem_wr, mq[m_idx].wr);
        check("mem_wstrb", mem_wstrb, mq[m_idx].wstrb);
        check("mem_wdata", mem_wdata, mq[m_idx].wdata);
      end
      check("data_ok", data_data_ok_m, exp_ok);
      check("rdata", data_rdata_m, exp_rdata);

      if (reset) begin
        mq.delete();
        exp_ok    = 1'b0;
        exp_rdata = '0;
      end else begin
        m_free = (mq.size() > 0) && mq[0].killed && !mq[0].issued && mq[0].gone;
        m_acc  = data_req && (mq.size() < DEPTH);
        if (m_idx >= 0) begin
          m_t = mq[m_idx];
          if (m_t.killed) m_t.gone = 1'b1;
          else if (!data_cancel && mem_addr_ok) m_t.issued = 1'b1;
          mq[m_idx] = m_t;
        end
        exp_ok    = 1'b0;
        exp_rdata = '0;
        if (mem_data_ok && mq.size() > 0) begin
          exp_ok    = !mq[0].killed && !data_cancel;
          exp_rdata = (exp_ok && !mq[0].wr) ? mem_rdata : 32'h0;
          void'(mq.pop_front());
        end else if (m_free) begin
          void'(mq.pop_front());
        end
        if (data_cancel)
          for (int i = 0; i < mq.size(); i++) begin
            m_t = mq[i];
            m_t.killed = 1'b1;
            mq[i] = m_t;
          end
        if (m_acc) begin
          m_t = '{wr: data_wr, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata,
                  killed: 1'b0, issued: 1'b0, gone: 1'b0};
          mq.push_back(m_t);
        end
      end
    end
  end

  // Memory-side stimulus helpers.
  logic [31:0] iss_q[$];
  bit          auto_mem  = 1'b0;
  bit          slow_mem  = 1'b0;
  bit          saw_80    = 1'b0;
  int          resp_seen = 0;
  int          cyc       = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (!reset && mem_req && mem_addr_ok) iss_q.push_back(mem_addr);
    if (mem_req && mem_addr == 32'h80) saw_80 = 1'b1;
    if (data_data_ok_m) resp_seen++;
    if (reset) iss_q.delete();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_mem) begin
      mem_data_ok = 1'b0;
      if (iss_q.size() > 0 && (!slow_mem || (cyc % 3) == 0)) begin
        mem_data_ok = 1'b1;
        mem_rdata   = mem_f(iss_q.pop_front());
      end
    end
  endtask

  task automatic respond();
    mem_data_ok = 1'b1;
    mem_rdata   = (iss_q.size() > 0) ? mem_f(iss_q.pop_front()) : 32'h0;
  endtask

  task automatic idle();
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wstrb  = '0;
    data_addr   = '0;
    data_wdata  = '0;
    data_cancel = 1'b0;
  endtask

  task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb);
    data_req   = 1'b1;
    data_wr    = wr;
    data_addr  = addr;
    data_wdata = wdata;
    data_wstrb = wstrb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    #2;
    check("rst_addr_ok", data_addr_ok, 0);
    check("rst_empty", data_req_empty, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_data_ok", data_data_ok_m, 0);
    check("rst_rdata", data_rdata_m, 0);
    tick();
    reset = 1'b0;
    #2 check("post_rst_addr_ok", data_addr_ok, 1);

    // Single load.
    req(1'b0, 32'h1C00_0100, 32'h0, 4'h0);
    tick();
    idle();
    mem_addr_ok = 1'b1;
    #2;
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_addr", mem_addr, 32'h1C00_0100);
    tick();
    mem_addr_ok = 1'b0;
    tick();
    tick();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hDEAD_BEEF;
    void'(iss_q.pop_front());
    tick();
    mem_data_ok = 1'b0;
    #2;
    check("t1_data_ok", data_data_ok_m, 1);
    check("t1_rdata", data_rdata_m, 32'hDEAD_BEEF);
    check("t1_empty", data_req_empty, 1);
    tick();

    // Fill with memory stalled, then release.
    auto_mem  = 1'b1;
    resp_seen = 0;
    for (int k = 0; k < 5; k++) begin
      req(1'b0, 32'h1000 + 32'(k * 4), 32'h0, 4'h0);
      #2 check($sformatf("t2_addr_ok_%0d", k), data_addr_ok, k < 4);
      tick();
    end
    mem_addr_ok = 1'b1;
    #2 check("t2_full_at_release", data_addr_ok, 0);
    tick();
    #2 check("t2_full_at_first_resp", data_addr_ok, 0);
    tick();
    #2 check("t2_fifth_accepted", data_addr_ok, 1);
    tick();
    idle();
    for (int i = 0; i < 30 && resp_seen < 5; i++) tick();
    check("t2_resp_count", resp_seen, 5);

    // Cancel an unissued store.
    auto_mem    = 1'b0;
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b0;
    tick();
    saw_80    = 1'b0;
    resp_seen = 0;
    req(1'b1, 32'h80, 32'h1234_5678, 4'hF);
    tick();
    idle();
    data_cancel = 1'b1;
    #2 check("t3_mem_req_in_cancel", mem_req, 0);
    tick();
    data_cancel = 1'b0;
    mem_addr_ok = 1'b1;
    tick();
    tick();
    tick();
    #2;
    check("t3_empty", data_req_empty, 1);
    check("t3_never_issued", saw_80, 0);
    check("t3_no_resp", resp_seen, 0);

    // Cancel an issued load; a load accepted in the cancel cycle survives.
    mem_addr_ok = 1'b0;
    req(1'b0, 32'h200, 32'h0, 4'h0);
    tick();
    idle();
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    req(1'b0, 32'h300, 32'h0, 4'h0);
    data_cancel = 1'b1;
    tick();
    idle();
    mem_addr_ok = 1'b1;
    respond();
    tick();
    mem_addr_ok = 1'b0;
    #2 check("t4_killed_no_resp", data_data_ok_m, 0);
    respond();
    tick();
    mem_data_ok = 1'b0;
    #2;
    check("t4_live_ok", data_data_ok_m, 1);
    check("t4_live_rdata", data_rdata_m, 32'hFFFF_FCFF);
    tick();

    // Twelve mixed transactions with slow memory: fills, wraps, accept+retire together.
    auto_mem  = 1'b1;
    slow_mem  = 1'b1;
    resp_seen = 0;
    n         = 0;
    for (int c = 0; c < 300 && n < 12; c++) begin
      req((n % 3) == 0, 32'h4000 + 32'(n * 4), 32'(n) * 32'h0101_0101, 4'(n));
      mem_addr_ok = (c % 4) != 3;
      #2 if (data_addr_ok) n++;
      tick();
    end
    idle();
    mem_addr_ok = 1'b1;
    for (int i = 0; i < 100 && resp_seen < 12; i++) tick();
    check("t5_accepted", n, 12);
    check("t5_resp_count", resp_seen, 12);
    slow_mem = 1'b0;
    auto_mem = 1'b0;
    mem_data_ok = 1'b0;
    tick();

    // Reset in the middle of traffic discards everything.
    resp_seen   = 0;
    mem_addr_ok = 1'b0;
    req(1'b0, 32'h500, 32'h0, 4'h0);
    tick();
    req(1'b0, 32'h504, 32'h0, 4'h0);
    tick();
    idle();
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2 check("t6_empty_after_reset", data_req_empty, 1);
    tick();
    tick();
    check("t6_no_resp", resp_seen, 0);

`ifdef CPU7_DBUS_PERF_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_addr_ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req(1'b0, 32'h600 + 32'(k * 4), 32'h0, 4'h0);
      tick();
    end
    req(1'b0, 32'h610, 32'h0, 4'h0);
    tick();
    tick();
    tick();
    idle();
    mem_addr_ok = 1'b1;
    tick();
    tick();
    mem_addr_ok = 1'b0;
    data_cancel = 1'b1;
    tick();
    data_cancel = 1'b0;
    respond();
    tick();
    respond();
    tick();
    mem_data_ok = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    check("perf_full_cycles", perf_full_cycles, 3);
    check("perf_killed_resp", perf_killed_resp, 2);
    reset = 1'b1;
    tick();
    #2;
    check("perf_full_rst", perf_full_cycles, 0);
    check("perf_killed_rst", perf_killed_resp, 0);
    reset = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
